// File: rtl/synth_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : synth_voice_allocator
// Purpose  : Sequential-scan voice allocator. Maps note-on/note-off events
//            onto NUM_VOICES oscillator channels, one voice inspected per
//            clock. Drives per-voice gate/note and a registered gate count.
// Options  : SYNTH_ALLOC_STEAL_EN - when defined, a note-on with every voice
//            gated steals the oldest voice; otherwise the note-on is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module synth_voice_allocator #(
  parameter int NUM_VOICES = 12,
  parameter int NOTE_BITS  = 7,
  parameter int AGE_BITS   = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_note_on,
  input  logic [NOTE_BITS-1:0]             ev_note,
  output logic [NUM_VOICES-1:0]            voice_gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0]  voice_note,
  output logic [$clog2(NUM_VOICES+1)-1:0]  active_count,
  output logic                             steal_pulse,
  output logic                             drop_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(NUM_VOICES+1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_VOICES-1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_ready;
  logic                   r_on;
  logic [NOTE_BITS-1:0]   r_note;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_match_vld;
  logic [IDX_W-1:0]       r_match_idx;
  logic                   r_free_vld;
  logic [IDX_W-1:0]       r_free_idx;
  logic                   r_old_vld;
  logic [IDX_W-1:0]       r_old_idx;
  logic [AGE_BITS-1:0]    r_old_age;

  logic [NUM_VOICES-1:0]  r_gate;
  logic [NOTE_BITS-1:0]   r_vnote [NUM_VOICES];
  logic [AGE_BITS-1:0]    r_age   [NUM_VOICES];
  logic [CNT_W-1:0]       r_count;
  logic                   r_steal;
  logic                   r_drop;

  // Voice under inspection this cycle
  logic                   w_cur_gate;
  logic [NOTE_BITS-1:0]   w_cur_note;
  logic [AGE_BITS-1:0]    w_cur_age;

  // Commit decision
  logic [NUM_VOICES-1:0]  w_gate_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_tgt_idx;
  logic                   w_wr_on;
  logic                   w_wr_off;
  logic                   w_steal_nxt;
  logic                   w_drop_nxt;

  assign w_cur_gate = r_gate[r_idx];
  assign w_cur_note = r_vnote[r_idx];
  assign w_cur_age  = r_age[r_idx];

  // Resolve the target voice and next gate vector from the scan candidates
  always_comb begin
    w_gate_nxt  = r_gate;
    w_tgt_idx   = '0;
    w_wr_on     = 1'b0;
    w_wr_off    = 1'b0;
    w_steal_nxt = 1'b0;
    w_drop_nxt  = 1'b0;
    w_cnt_nxt   = '0;
    if (r_on) begin
      if (r_match_vld) begin
        w_tgt_idx = r_match_idx;
        w_wr_on   = 1'b1;
      end else if (r_free_vld) begin
        w_tgt_idx = r_free_idx;
        w_wr_on   = 1'b1;
      end else begin
`ifdef SYNTH_ALLOC_STEAL_EN
        w_tgt_idx   = r_old_idx;
        w_wr_on     = 1'b1;
        w_steal_nxt = 1'b1;
`else
        w_drop_nxt  = 1'b1;
`endif
      end
    end else if (r_match_vld) begin
      w_tgt_idx = r_match_idx;
      w_wr_off  = 1'b1;
    end
    if (w_wr_on) begin
      w_gate_nxt[w_tgt_idx] = 1'b1;
    end
    if (w_wr_off) begin
      w_gate_nxt[w_tgt_idx] = 1'b0;
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_gate_nxt[v]);
    end
  end

  // Control FSM: accept, scan one voice per cycle, commit, with candidate tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_on        <= 1'b0;
      r_note      <= '0;
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_old_vld   <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ev_valid && r_ready) begin
            r_on        <= ev_note_on;
            r_note      <= ev_note;
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_match_idx <= '0;
            r_free_vld  <= 1'b0;
            r_free_idx  <= '0;
            r_old_vld   <= 1'b0;
            r_old_idx   <= '0;
            r_old_age   <= '0;
            r_ready     <= 1'b0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_cur_gate && (w_cur_note == r_note) && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!w_cur_gate && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
          // Strict compare keeps the lower index on equal ages
          if (w_cur_gate && (!r_old_vld || (w_cur_age > r_old_age))) begin
            r_old_vld <= 1'b1;
            r_old_idx <= r_idx;
            r_old_age <= w_cur_age;
          end
          if (r_idx == C_LAST_IDX) begin
            r_state <= ST_COMMIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Voice state, gate count and event pulses, updated only on the commit edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gate  <= '0;
      r_count <= '0;
      r_steal <= 1'b0;
      r_drop  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_vnote[v] <= '0;
        r_age[v]   <= '0;
      end
    end else begin
      r_steal <= 1'b0;
      r_drop  <= 1'b0;
      if (r_state == ST_COMMIT) begin
        r_gate  <= w_gate_nxt;
        r_count <= w_cnt_nxt;
        r_steal <= w_steal_nxt;
        r_drop  <= w_drop_nxt;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (w_wr_on) begin
            if (IDX_W'(v) == w_tgt_idx) begin
              r_vnote[v] <= r_note;
              r_age[v]   <= '0;
            end else if (r_gate[v] && (r_age[v] != {AGE_BITS{1'b1}})) begin
              r_age[v] <= r_age[v] + 1'b1;
            end
          end else if (w_wr_off && (IDX_W'(v) == w_tgt_idx)) begin
            // Released voices rest at age 0; the note value is held
            r_age[v] <= '0;
          end
        end
      end
    end
  end

  assign ev_ready     = r_ready;
  assign voice_gate   = r_gate;
  assign active_count = r_count;
  assign steal_pulse  = r_steal;
  assign drop_pulse   = r_drop;

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_note[g*NOTE_BITS +: NOTE_BITS] = r_vnote[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_synth_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_voice_allocator
// Purpose  : Directed self-checking bench for synth_voice_allocator.
//            Expected values follow SYNTH_ALLOC_STEAL_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synth_voice_allocator;

  localparam int NV = 12;
  localparam int NB = 7;
  localparam int CW = $clog2(NV+1);

  logic             clk;
  logic             resetn;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_note_on;
  logic [NB-1:0]    ev_note;
  logic [NV-1:0]    voice_gate;
  logic [NV*NB-1:0] voice_note;
  logic [CW-1:0]    active_count;
  logic             steal_pulse;
  logic             drop_pulse;

  int n_vec;
  int n_err;
  int last_busy;
  logic p1s, p1d, p2s, p2d;
  logic [NV*NB-1:0] snap_notes;

  synth_voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .AGE_BITS(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_note      (ev_note),
    .voice_gate   (voice_gate),
    .voice_note   (voice_note),
    .active_count (active_count),
    .steal_pulse  (steal_pulse),
    .drop_pulse   (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] vnote(input int v);
    return voice_note[v*NB +: NB];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one event at a negedge, then wait for the allocator to become ready
  task automatic send(input logic on, input logic [NB-1:0] n);
    int t;
    t = 0;
    while (!ev_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ev_note_on = on;
    ev_note    = n;
    ev_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    last_busy = 0;
    while (!ev_ready && last_busy < 50) begin
      last_busy++;
      @(negedge clk);
    end
    p1s = steal_pulse;
    p1d = drop_pulse;
    @(negedge clk);
    p2s = steal_pulse;
    p2d = drop_pulse;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    ev_valid = 1'b0;
    ev_note_on = 1'b0;
    ev_note = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_gate", voice_gate, 0);
    chk("rst_notes", voice_note, 0);
    chk("rst_count", active_count, 0);
    chk("rst_pulses", {steal_pulse, drop_pulse}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", ev_ready, 1);

    // First note-on lands in voice 0
    send(1'b1, 7'd60);
    chk("on60_busy", last_busy, 13);
    chk("on60_gate", voice_gate, 12'h001);
    chk("on60_note", vnote(0), 60);
    chk("on60_count", active_count, 1);
    chk("on60_pulses", {p1s, p1d, p2s, p2d}, 0);

    // Same note again retriggers voice 0
    send(1'b1, 7'd60);
    chk("retrig_gate", voice_gate, 12'h001);
    chk("retrig_count", active_count, 1);
    chk("retrig_pulses", {p1s, p1d}, 0);

    // Chord then release the middle note
    send(1'b1, 7'd64);
    send(1'b1, 7'd67);
    chk("chord_gate", voice_gate, 12'h007);
    chk("chord_v2", vnote(2), 67);
    send(1'b0, 7'd64);
    chk("off64_gate", voice_gate, 12'h005);
    chk("off64_count", active_count, 2);
    chk("off64_v1note", vnote(1), 64);

    // Release of a note nobody holds
    snap_notes = voice_note;
    send(1'b0, 7'd99);
    chk("off99_busy", last_busy, 13);
    chk("off99_gate", voice_gate, 12'h005);
    chk("off99_notes", voice_note, snap_notes);
    chk("off99_count", active_count, 2);
    chk("off99_pulses", {p1s, p1d}, 0);

    // Fill all voices
    do_reset();
    for (int i = 0; i < NV; i++) begin
      send(1'b1, 7'(40 + i));
    end
    chk("full_gate", voice_gate, 12'hFFF);
    chk("full_count", active_count, 12);
    chk("full_v11", vnote(11), 51);

    // Note-on with every voice gated
    snap_notes = voice_note;
    send(1'b1, 7'd72);
`ifdef SYNTH_ALLOC_STEAL_EN
    chk("steal_v0", vnote(0), 72);
    chk("steal_pulse", {p1s, p2s}, 2'b10);
    chk("steal_drop", {p1d, p2d}, 0);
`else
    chk("drop_notes", voice_note, snap_notes);
    chk("drop_pulse", {p1d, p2d}, 2'b10);
    chk("drop_steal", {p1s, p2s}, 0);
`endif
    chk("full2_gate", voice_gate, 12'hFFF);
    chk("full2_count", active_count, 12);

    // Second overflow: the oldest is now voice 1
    send(1'b1, 7'd73);
`ifdef SYNTH_ALLOC_STEAL_EN
    chk("steal2_v1", vnote(1), 73);
    chk("steal2_v0", vnote(0), 72);
    chk("steal2_pulse", p1s, 1);
`else
    chk("drop2_v1", vnote(1), 41);
    chk("drop2_pulse", p1d, 1);
`endif

    // Free voice preferred over stealing
    send(1'b0, 7'd45);
    chk("off45_gate", voice_gate, 12'hFDF);
    chk("off45_count", active_count, 11);
    send(1'b1, 7'd80);
    chk("free_v5", vnote(5), 80);
    chk("free_gate", voice_gate, 12'hFFF);
    chk("free_pulses", {p1s, p1d}, 0);

    // Reset in the middle of a scan
    do_reset();
    send(1'b1, 7'd30);
    chk("pre_gate", voice_gate, 12'h001);
    ev_note_on = 1'b1;
    ev_note    = 7'd61;
    ev_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_gate", voice_gate, 0);
    chk("mid_notes", voice_note, 0);
    chk("mid_count", active_count, 0);
    chk("mid_pulses", {steal_pulse, drop_pulse}, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_ready", ev_ready, 1);
    chk("mid_gate_after", voice_gate, 0);
    chk("mid_count_after", active_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
